// File: rtl/ddr_arb_pkg.sv
// Shared types and helpers for the round-robin DDR arbiter: command codes,
// FSM state encoding and the cyclic priority pick used by rr_arbiter.
package ddr_arb_pkg;

    localparam logic [2:0] CMD_RD = 3'b001;
    localparam logic [2:0] CMD_WR = 3'b000;

    // Client indices are carried in a fixed 3-bit field (up to 8 clients).
    localparam int MAX_CLIENTS = 8;
    localparam int IDX_W       = 3;

    typedef enum logic [1:0] {
        ST_PCIE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_t;

    // First requester at or after ptr, scanning cyclically over n clients.
    // Returns ptr unchanged when nobody requests; callers qualify with |req.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [MAX_CLIENTS-1:0] req,
        input logic [IDX_W-1:0]       ptr,
        input int                     n
    );
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] idx;
        logic             found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < MAX_CLIENTS; i++) begin
            idx = IDX_W'((int'(ptr) + i) % n);
            if (i < n && !found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/ddr_iface_arbiter_rr_if.sv
// MIG native command/write-data/read-return bus between the arbiter (master)
// and the DDR controller (slave).
interface ddr_iface_arbiter_rr_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 512
) ();

    // Handshake: a command transfers on every cycle where ddr_en && ddr_rdy.
    // ddr_en may drop without a transfer (ownership change, read throttling);
    // write data moves with ddr_wdf_wren, read beats arrive on
    // ddr_rd_data_valid with ddr_rd_data_end marking the last beat of a read.
    logic                  ddr_rdy;
    logic                  ddr_rd_data_valid;
    logic                  ddr_rd_data_end;
    logic [ADDR_W-1:0]     ddr_addr;
    logic [2:0]            ddr_cmd;
    logic                  ddr_en;
    logic [DATA_W-1:0]     ddr_wdf_data;
    logic [DATA_W/8-1:0]   ddr_wdf_mask;
    logic                  ddr_wdf_wren;
    logic                  ddr_wdf_end;

    modport master (
        input  ddr_rdy, ddr_rd_data_valid, ddr_rd_data_end,
        output ddr_addr, ddr_cmd, ddr_en, ddr_wdf_data, ddr_wdf_mask,
               ddr_wdf_wren, ddr_wdf_end
    );

    modport slave (
        output ddr_rdy, ddr_rd_data_valid, ddr_rd_data_end,
        input  ddr_addr, ddr_cmd, ddr_en, ddr_wdf_data, ddr_wdf_mask,
               ddr_wdf_wren, ddr_wdf_end
    );

endinterface

// File: rtl/ddr_iface_arbiter_rr_rr_arbiter.sv
// N-bit cyclic priority encoder: picks the first requester at or after ptr.
module rr_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] pick,
    output logic             any
);

    logic [MAX_CLIENTS-1:0] req_ext;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
    end

    assign pick = rr_pick(req_ext, ptr, N);
    assign any  = |req;

endmodule

// File: rtl/ddr_iface_arbiter_rr.sv
// Round-robin DDR arbiter: PCIe owns the MIG bus while disabled, vgg clients
// share it while enabled, with hold limit, read drain and read-return routing.
module ddr_iface_arbiter_rr
    import ddr_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_W      = 30,
    parameter int DATA_W      = 512,
    parameter int MAX_HOLD    = 64,
    parameter int OSTD_W      = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    ddr_iface_arbiter_rr_if.master        ddr,
    input  logic                          arb_data_ready,
    input  logic                          arb_cnn_finish,
    input  logic [ADDR_W-1:0]             arb_pcie_addr,
    input  logic [2:0]                    arb_pcie_cmd,
    input  logic                          arb_pcie_en,
    input  logic [DATA_W-1:0]             arb_pcie_wdf_data,
    input  logic                          arb_pcie_wdf_wren,
    input  logic [NUM_CLIENTS-1:0]        arb_cl_req,
    output logic [NUM_CLIENTS-1:0]        arb_cl_grant,
    output logic [NUM_CLIENTS-1:0]        arb_cl_rd_valid,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] arb_cl_addr,
    input  logic [NUM_CLIENTS*3-1:0]      arb_cl_cmd,
    input  logic [NUM_CLIENTS-1:0]        arb_cl_en,
    input  logic [NUM_CLIENTS*DATA_W-1:0] arb_cl_wdf_data,
    input  logic [NUM_CLIENTS-1:0]        arb_cl_wdf_wren,
    output arb_state_t                    dbg_state
);

    localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic [OSTD_W-1:0] OSTD_MAX = '1;

    arb_state_t             state;
    logic                   en_r;
    logic [IDX_W-1:0]       owner;
    logic [IDX_W-1:0]       rr_ptr;
    logic [HOLD_W-1:0]      hold_cnt;
    logic [OSTD_W-1:0]      ostd;
    logic [NUM_CLIENTS-1:0] grant_r;

    logic [IDX_W-1:0]       pick;
    logic                   any_req;
    logic [NUM_CLIENTS-1:0] pick_onehot;
    logic [IDX_W-1:0]       next_ptr;

    logic [ADDR_W-1:0]      own_addr;
    logic [2:0]             own_cmd;
    logic                   own_en;
    logic                   own_wren;
    logic                   own_req;
    logic [DATA_W-1:0]      own_data;
    logic                   others_req;

    logic                   hold_full;
    logic                   release_now;
    logic                   grant_live;
    logic                   is_rd;
    logic                   cl_en_gated;
    logic                   accept;
    logic                   accept_rd;
    logic                   rd_ret;

    logic [ADDR_W-1:0]      mux_addr;
    logic [2:0]             mux_cmd;
    logic                   mux_en;
    logic [DATA_W-1:0]      mux_data;
    logic                   mux_wren;

    rr_arbiter #(.N(NUM_CLIENTS)) u_rr (
        .req  (arb_cl_req),
        .ptr  (rr_ptr),
        .pick (pick),
        .any  (any_req)
    );

    always_comb begin
        pick_onehot = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (pick == IDX_W'(i)) pick_onehot[i] = 1'b1;
        end
    end

    assign next_ptr = (owner == IDX_W'(NUM_CLIENTS - 1)) ? '0 : owner + 1'b1;

    // Select the current owner's command lanes and note competing requests.
    always_comb begin
        own_addr   = arb_cl_addr[ADDR_W-1:0];
        own_cmd    = arb_cl_cmd[2:0];
        own_data   = arb_cl_wdf_data[DATA_W-1:0];
        own_en     = 1'b0;
        own_wren   = 1'b0;
        own_req    = 1'b0;
        others_req = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (owner == IDX_W'(i)) begin
                own_addr = arb_cl_addr[i*ADDR_W +: ADDR_W];
                own_cmd  = arb_cl_cmd[i*3 +: 3];
                own_data = arb_cl_wdf_data[i*DATA_W +: DATA_W];
                own_en   = arb_cl_en[i];
                own_wren = arb_cl_wdf_wren[i];
                own_req  = arb_cl_req[i];
            end else if (arb_cl_req[i]) begin
                others_req = 1'b1;
            end
        end
    end

    // The release cycle carries no command, so a grant sees exactly MAX_HOLD
    // accepts before handing over to a waiting client.
    assign hold_full   = (hold_cnt == HOLD_W'(MAX_HOLD));
    assign release_now = (state == ST_GRANT) &&
                         (!own_req || (hold_full && others_req) || !en_r);
    assign grant_live  = (state == ST_GRANT) && !release_now;
    assign is_rd       = (own_cmd == CMD_RD);
    assign cl_en_gated = grant_live && own_en && !(is_rd && (ostd == OSTD_MAX));
    assign accept      = cl_en_gated && ddr.ddr_rdy;
    assign accept_rd   = accept && is_rd;
    assign rd_ret      = ddr.ddr_rd_data_valid && ddr.ddr_rd_data_end;

    always_comb begin
        if (state == ST_PCIE) begin
            mux_addr = arb_pcie_addr;
            mux_cmd  = arb_pcie_cmd;
            mux_en   = arb_pcie_en;
            mux_data = arb_pcie_wdf_data;
            mux_wren = arb_pcie_wdf_wren;
        end else begin
            mux_addr = own_addr;
            mux_cmd  = own_cmd;
            mux_en   = cl_en_gated;
            mux_data = own_data;
            mux_wren = grant_live && own_wren;
        end
    end

    assign ddr.ddr_addr     = mux_addr;
    assign ddr.ddr_cmd      = mux_cmd;
    assign ddr.ddr_en       = mux_en;
    assign ddr.ddr_wdf_data = mux_data;
    assign ddr.ddr_wdf_mask = '0;
    assign ddr.ddr_wdf_wren = mux_wren;
    assign ddr.ddr_wdf_end  = mux_wren;

    // Read beats go to whoever owns the bus; DRAIN keeps the last owner.
    always_comb begin
        arb_cl_rd_valid = '0;
        if (state != ST_PCIE) begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                if (owner == IDX_W'(i)) arb_cl_rd_valid[i] = ddr.ddr_rd_data_valid;
            end
        end
    end

    assign arb_cl_grant = grant_r;
    assign dbg_state    = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ostd <= '0;
        end else begin
            case ({accept_rd, rd_ret})
                2'b10:   ostd <= ostd + 1'b1;
                2'b01:   if (ostd != '0) ostd <= ostd - 1'b1;
                default: ostd <= ostd;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_PCIE;
            en_r     <= 1'b0;
            owner    <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            grant_r  <= '0;
        end else begin
            if (arb_data_ready) begin
                en_r <= 1'b1;
            end else if (arb_cnn_finish) begin
                en_r <= 1'b0;
            end

            case (state)
                ST_PCIE: begin
                    if (en_r && any_req) begin
                        owner    <= pick;
                        grant_r  <= pick_onehot;
                        hold_cnt <= '0;
                        state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        grant_r  <= '0;
                        rr_ptr   <= next_ptr;
                        hold_cnt <= '0;
                        state    <= ST_DRAIN;
                    end else if (hold_full) begin
                        hold_cnt <= accept ? HOLD_W'(1) : '0;
                    end else if (accept) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (ostd == '0) begin
                        if (en_r && any_req) begin
                            owner    <= pick;
                            grant_r  <= pick_onehot;
                            hold_cnt <= '0;
                            state    <= ST_GRANT;
                        end else begin
                            state <= ST_PCIE;
                        end
                    end
                end
                default: state <= ST_PCIE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_iface_arbiter_rr.sv
// Self-checking bench for ddr_iface_arbiter_rr: command-order and read-routing
// scoreboards plus directed checks on grant order, hold limit and draining.
module tb_ddr_iface_arbiter_rr;
    import ddr_arb_pkg::*;

    localparam int NC = 4;
    localparam int AW = 30;
    localparam int DW = 512;
    localparam int MH = 4;
    localparam int OW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              arb_data_ready;
    logic              arb_cnn_finish;
    logic [AW-1:0]     arb_pcie_addr;
    logic [2:0]        arb_pcie_cmd;
    logic              arb_pcie_en;
    logic [DW-1:0]     arb_pcie_wdf_data;
    logic              arb_pcie_wdf_wren;
    logic [NC-1:0]     arb_cl_req;
    logic [NC-1:0]     arb_cl_grant;
    logic [NC-1:0]     arb_cl_rd_valid;
    logic [NC*AW-1:0]  arb_cl_addr;
    logic [NC*3-1:0]   arb_cl_cmd;
    logic [NC-1:0]     arb_cl_en;
    logic [NC*DW-1:0]  arb_cl_wdf_data;
    logic [NC-1:0]     arb_cl_wdf_wren;
    arb_state_t        dbg_state;

    ddr_iface_arbiter_rr_if #(.ADDR_W(AW), .DATA_W(DW)) ddr ();

    ddr_iface_arbiter_rr #(
        .NUM_CLIENTS (NC),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .MAX_HOLD    (MH),
        .OSTD_W      (OW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .ddr               (ddr),
        .arb_data_ready    (arb_data_ready),
        .arb_cnn_finish    (arb_cnn_finish),
        .arb_pcie_addr     (arb_pcie_addr),
        .arb_pcie_cmd      (arb_pcie_cmd),
        .arb_pcie_en       (arb_pcie_en),
        .arb_pcie_wdf_data (arb_pcie_wdf_data),
        .arb_pcie_wdf_wren (arb_pcie_wdf_wren),
        .arb_cl_req        (arb_cl_req),
        .arb_cl_grant      (arb_cl_grant),
        .arb_cl_rd_valid   (arb_cl_rd_valid),
        .arb_cl_addr       (arb_cl_addr),
        .arb_cl_cmd        (arb_cl_cmd),
        .arb_cl_en         (arb_cl_en),
        .arb_cl_wdf_data   (arb_cl_wdf_data),
        .arb_cl_wdf_wren   (arb_cl_wdf_wren),
        .dbg_state         (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [AW+2:0] exp_q[$];
    logic [NC-1:0] rd_exp_q[$];

    logic          cl_on[NC];
    logic [2:0]    cl_kind[NC];
    logic [AW-1:0] cl_base[NC];
    int            acc_cnt[NC];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst               = 1'b1;
        arb_data_ready    = 1'b0;
        arb_cnn_finish    = 1'b0;
        arb_pcie_addr     = '0;
        arb_pcie_cmd      = CMD_WR;
        arb_pcie_en       = 1'b0;
        arb_pcie_wdf_data = '0;
        arb_pcie_wdf_wren = 1'b0;
        arb_cl_req        = '0;
        arb_cl_addr       = '0;
        arb_cl_cmd        = '0;
        arb_cl_en         = '0;
        arb_cl_wdf_data   = '0;
        arb_cl_wdf_wren   = '0;
        ddr.ddr_rdy           = 1'b1;
        ddr.ddr_rd_data_valid = 1'b0;
        ddr.ddr_rd_data_end   = 1'b0;
        for (int i = 0; i < NC; i++) begin
            cl_on[i]   = 1'b0;
            cl_kind[i] = CMD_WR;
            cl_base[i] = '0;
            acc_cnt[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_clients();
        logic [AW-1:0] a;
        for (int i = 0; i < NC; i++) begin
            a = cl_base[i] + AW'(acc_cnt[i]);
            arb_cl_en[i]                = cl_on[i];
            arb_cl_cmd[i*3 +: 3]        = cl_kind[i];
            arb_cl_addr[i*AW +: AW]     = a;
            arb_cl_wdf_wren[i]          = cl_on[i] && (cl_kind[i] == CMD_WR);
            arb_cl_wdf_data[i*DW +: DW] = DW'(a);
        end
    endtask

    task automatic pulse_ready();
        arb_data_ready = 1'b1;
        tick();
        arb_data_ready = 1'b0;
    endtask

    // Each client walks its own address sequence, advancing on its accepts.
    task automatic run_stream(input int target, input int budget);
        int total;
        total = 0;
        for (int c = 0; c < budget && total < target; c++) begin
            drive_clients();
            @(negedge clk);
            for (int i = 0; i < NC; i++) begin
                if (arb_cl_grant[i] && ddr.ddr_en && ddr.ddr_rdy) begin
                    acc_cnt[i]++;
                    total++;
                end
            end
            tick();
        end
        check("stream_accepts", total, target);
    endtask

    task automatic rd_beat(input logic [NC-1:0] exp_rdv);
        rd_exp_q.push_back(exp_rdv);
        ddr.ddr_rd_data_valid = 1'b1;
        ddr.ddr_rd_data_end   = 1'b1;
        @(negedge clk);
        check("rd_beat_no_cmd", ddr.ddr_en, 0);
        tick();
        ddr.ddr_rd_data_valid = 1'b0;
        ddr.ddr_rd_data_end   = 1'b0;
    endtask

    task automatic wait_grant(input string tag, input logic [NC-1:0] exp, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (arb_cl_grant != '0) break;
        end
        check(tag, arb_cl_grant, exp);
        tick();
    endtask

    task automatic wait_state(input string tag, input arb_state_t st, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (dbg_state == st) break;
        end
        check(tag, dbg_state, st);
        tick();
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && ddr.ddr_en && ddr.ddr_rdy) begin
            if (exp_q.size() == 0) check("cmd_unexpected", exp_q.size(), 1);
            else check("ddr_cmd", {ddr.ddr_cmd, ddr.ddr_addr}, exp_q.pop_front());
        end
        if (!rst && ddr.ddr_rd_data_valid) begin
            if (rd_exp_q.size() == 0) check("rd_unexpected", rd_exp_q.size(), 1);
            else check("rd_route", arb_cl_rd_valid, rd_exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        // PCIe passthrough after reset
        do_reset();
        check("rst_grant", arb_cl_grant, 0);
        check("rst_state", dbg_state, ST_PCIE);
        exp_q.push_back({CMD_WR, AW'(32'h100)});
        arb_pcie_addr     = AW'(32'h100);
        arb_pcie_cmd      = CMD_WR;
        arb_pcie_en       = 1'b1;
        arb_pcie_wdf_wren = 1'b1;
        arb_pcie_wdf_data = DW'(64'hABCD);
        @(negedge clk);
        check("pcie_addr", ddr.ddr_addr, 64'h100);
        check("pcie_en", ddr.ddr_en, 1);
        check("pcie_grant", arb_cl_grant, 0);
        check("pcie_wdata", ddr.ddr_wdf_data[63:0], 64'hABCD);
        check("wdf_mask", ddr.ddr_wdf_mask, 0);
        check("wdf_end", ddr.ddr_wdf_end, 1);
        tick();
        arb_pcie_en       = 1'b0;
        arb_pcie_wdf_wren = 1'b0;
        @(negedge clk);
        check("pcie_en_off", ddr.ddr_en, 0);
        tick();

        // Grant order 1 then 2; ready and finish together must enable
        do_reset();
        arb_cl_req     = 4'b0110;
        arb_data_ready = 1'b1;
        arb_cnn_finish = 1'b1;
        tick();
        arb_data_ready = 1'b0;
        arb_cnn_finish = 1'b0;
        @(negedge clk);
        check("grant_lat", arb_cl_grant, 0);
        tick();
        @(negedge clk);
        check("grant_first", arb_cl_grant, 4'b0010);
        tick();
        arb_cl_req = 4'b0100;
        tick();
        @(negedge clk);
        check("drain_gap_state", dbg_state, ST_DRAIN);
        check("drain_gap_grant", arb_cl_grant, 0);
        wait_grant("grant_second", 4'b0100, 10);

        // Hold limit: clients 0 and 2 alternate, 4 writes per grant
        do_reset();
        cl_on[0] = 1'b1; cl_base[0] = AW'(32'h000);
        cl_on[2] = 1'b1; cl_base[2] = AW'(32'h200);
        for (int k = 0; k < 4; k++) exp_q.push_back({CMD_WR, AW'(32'h000 + k)});
        for (int k = 0; k < 4; k++) exp_q.push_back({CMD_WR, AW'(32'h200 + k)});
        for (int k = 4; k < 8; k++) exp_q.push_back({CMD_WR, AW'(32'h000 + k)});
        arb_cl_req = 4'b0101;
        pulse_ready();
        run_stream(12, 60);
        arb_cl_req = '0;
        cl_on[0] = 1'b0;
        cl_on[2] = 1'b0;
        drive_clients();
        check("hold_q_left", exp_q.size(), 0);
        tick();

        // Outstanding-read limit, then drain before handing to client 3
        do_reset();
        cl_on[1] = 1'b1; cl_kind[1] = CMD_RD; cl_base[1] = AW'(32'h400);
        for (int k = 0; k < 4; k++) exp_q.push_back({CMD_RD, AW'(32'h400 + k)});
        arb_cl_req = 4'b1010;
        pulse_ready();
        run_stream(3, 20);
        drive_clients();
        @(negedge clk);
        check("ostd_block", ddr.ddr_en, 0);
        tick();
        rd_beat(4'b0010);
        run_stream(1, 5);
        cl_on[1] = 1'b0;
        arb_cl_req = 4'b1000;
        drive_clients();
        tick();
        @(negedge clk);
        check("rd_drain_state", dbg_state, ST_DRAIN);
        check("rd_drain_grant", arb_cl_grant, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            rd_beat(4'b0010);
            @(negedge clk);
            check("drain_hold", arb_cl_grant, 0);
            tick();
        end
        wait_grant("grant_after_drain", 4'b1000, 10);

        // cnn_finish with one read in flight: DRAIN, return, PCIE
        cl_on[3] = 1'b1; cl_kind[3] = CMD_RD; cl_base[3] = AW'(32'h700);
        exp_q.push_back({CMD_RD, AW'(32'h700)});
        run_stream(1, 5);
        cl_on[3] = 1'b0;
        drive_clients();
        arb_cnn_finish = 1'b1;
        tick();
        arb_cnn_finish = 1'b0;
        wait_state("finish_drain", ST_DRAIN, 5);
        check("finish_grant", arb_cl_grant, 0);
        rd_beat(4'b1000);
        wait_state("finish_pcie", ST_PCIE, 5);
        exp_q.push_back({CMD_RD, AW'(32'h180)});
        arb_pcie_addr = AW'(32'h180);
        arb_pcie_cmd  = CMD_RD;
        arb_pcie_en   = 1'b1;
        @(negedge clk);
        check("pcie_back_addr", ddr.ddr_addr, 64'h180);
        tick();
        arb_pcie_en = 1'b0;

        // Reset in the middle of a grant
        arb_cl_req = 4'b0001;
        pulse_ready();
        wait_grant("grant_c0", 4'b0001, 10);
        rst                   = 1'b1;
        arb_pcie_en           = 1'b1;
        arb_pcie_addr         = AW'(32'h1AB);
        ddr.ddr_rd_data_valid = 1'b1;
        #1;
        check("midrst_grant", arb_cl_grant, 0);
        check("midrst_rdv", arb_cl_rd_valid, 0);
        check("midrst_state", dbg_state, ST_PCIE);
        check("midrst_en", ddr.ddr_en, 1);
        check("midrst_addr", ddr.ddr_addr, 64'h1AB);
        arb_pcie_en           = 1'b0;
        ddr.ddr_rd_data_valid = 1'b0;
        arb_cl_req            = '0;
        tick();
        rst = 1'b0;
        tick();

        // ---------------- final report ----------------
        check("cmd_q_empty", exp_q.size(), 0);
        check("rd_q_empty", rd_exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ddr_iface_arbiter_rr.md
Name: ddr_iface_arbiter_rr

Overview:
N-client round-robin DDR (MIG native) arbiter; successor to the fixed conv/fc arbiter. PCIe owns DDR while disabled; vgg clients (conv, fc, pool, ...) share it while enabled. Adds a grant-hold limit, read drain before ownership change, read-return routing and outstanding-read backpressure.

Parameters:
NUM_CLIENTS, 4, number of vgg-side requestors (2..8); client 0 wins after reset
ADDR_W, 30, DDR address width
DATA_W, 512, DDR data width; mask width is DATA_W/8
MAX_HOLD, 64, accepted commands per grant before forced release when another client requests
OSTD_W, 5, outstanding-read counter width; limit is 2**OSTD_W-1

Ports:
clk  in  1  clock
rst  in  1  async reset, active-high
ddr_rdy  in  1  MIG accepts command this cycle
ddr_rd_data_valid  in  1  read beat valid
ddr_rd_data_end  in  1  last beat of a read command
ddr_addr  out  ADDR_W  muxed address
ddr_cmd  out  3  muxed command: 3'b001 read, 3'b000 write
ddr_en  out  1  gated command enable
ddr_wdf_data  out  DATA_W  muxed write data
ddr_wdf_mask  out  DATA_W/8  constant 0 (all bytes written)
ddr_wdf_wren  out  1  gated write-data enable
ddr_wdf_end  out  1  equals ddr_wdf_wren (single-beat writes)
arb_data_ready  in  1  pulse: enable arbitration
arb_cnn_finish  in  1  pulse: disable arbitration, return DDR to PCIe
arb_pcie_addr  in  ADDR_W  PCIe address
arb_pcie_cmd  in  3  PCIe command
arb_pcie_en  in  1  PCIe enable
arb_pcie_wdf_data  in  DATA_W  PCIe write data
arb_pcie_wdf_wren  in  1  PCIe write enable
arb_cl_req  in  NUM_CLIENTS  per-client request
arb_cl_grant  out  NUM_CLIENTS  one-hot live grant
arb_cl_rd_valid  out  NUM_CLIENTS  read beat belongs to client i; data taken from the MIG read bus
arb_cl_addr  in  NUM_CLIENTS*ADDR_W  flattened, client i at [i*ADDR_W +: ADDR_W]
arb_cl_cmd  in  NUM_CLIENTS*3  flattened commands
arb_cl_en  in  NUM_CLIENTS  per-client enable
arb_cl_wdf_data  in  NUM_CLIENTS*DATA_W  flattened write data
arb_cl_wdf_wren  in  NUM_CLIENTS  per-client write enable

Behaviour:
- Reset: state PCIE, en_r=0, owner=0, rr pointer=0, hold_cnt=0, ostd=0, grant=0, rd_valid=0. Outputs mux PCIe (ddr_en = arb_pcie_en).
- en_r: set on arb_data_ready; else cleared on arb_cnn_finish; ready wins if both are asserted.
- States: PCIE, GRANT, DRAIN.
- PCIE: PCIe muxed through. If en_r && |req, set owner to the first requester at or after the rr pointer (cyclic), then go to GRANT next cycle with hold_cnt=0. Otherwise stay in PCIE.
- GRANT: arb_cl_grant[owner]=1. Owner's signals muxed.
  - ddr_en = en & !(read && ostd==max).
  - Accept = ddr_en && ddr_rdy; each accept increments hold_cnt.
  - Go to DRAIN, rr pointer = owner+1 mod N, when any of these holds:
    - req[owner] drops.
    - hold_cnt==MAX_HOLD and another req is pending.
    - en_r==0.
  - If hold_cnt==MAX_HOLD and no other req is pending, hold_cnt resets and the grant is kept.
- DRAIN: grant=0, ddr_en=0, wren=0. Wait for ostd==0, then:
  - en_r && |req: re-arbitrate straight to GRANT.
  - Otherwise: go to PCIE.
  - Never hand over with reads in flight.
- ostd: +1 on accepted read, -1 on valid&&end; unchanged when both occur. Never wraps; increments are gated at max.
- rd_valid[owner]=ddr_rd_data_valid, combinational, during GRANT and DRAIN.
- Mux is combinational; latency from req to grant is 1 cycle from PCIE, and from release to a new grant is ≥1 DRAIN cycle.

Decomposition:
- Package ddr_arb_pkg: CMD_RD/CMD_WR constants, state enum, and the rr_pick(req, ptr) function.
- One sub-module: rr_arbiter (N-bit cyclic priority encoder).

Test Plan:
- Reset, en_r=0, PCIe write addr 0x100 -> ddr_addr=0x100, ddr_en follows pcie_en, grant=0.
- data_ready, req=4'b0110 -> grant=4'b0010, then 4'b0100 after client1 drops req.
- MAX_HOLD=4, clients 0 and 2 stream writes with ddr_rdy=1 -> exactly 4 accepts per grant, alternating 0,2,0.
- Client1 issues 3 reads then drops req -> DRAIN until the 3rd rd_data_end; rd_valid=4'b0010 on each beat; next grant only afterwards.
- OSTD_W=2, 4 reads back-to-back -> 4th read has ddr_en=0 until one read returns.
- cnn_finish during GRANT with 1 read pending -> DRAIN, return, then PCIE. Reset mid-GRANT -> all outputs at reset values immediately.
